vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source for the VGA display path; the stage directly upstream of the sprite/text pixel mux.
//  Divides CLK into a 1-in-CLK_DIV pixel enable and runs the 800x525 raster counters (640x480@60 default).
//  Drives HSync/VSync, active-video, line/frame strobes and a frame counter for software polling.
//  Exports one-pixel-ahead coordinates so synchronous sprite/char ROMs have a full pixel period to respond.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync width (lines)
//  V_BP      33   vertical back porch (lines)
//  CLK_DIV   4    CLK cycles per pixel; must be >= 2
// PORTS
//  CLK         in   1   system clock; all logic on posedge
//  CLR         in   1   synchronous active-high reset
//  pixEn       out  1   high for one CLK in every CLK_DIV; raster advances at the edge ending this cycle
//  HSync       out  1   horizontal sync, active low
//  VSync       out  1   vertical sync, active low
//  HPix        out  10  current pixel column, 0..H_TOTAL-1
//  VPix        out  10  current line, 0..V_TOTAL-1
//  active      out  1   HPix<H_ACTIVE && VPix<V_ACTIVE
//  vblank      out  1   VPix>=V_ACTIVE
//  nextHPix    out  10  column the raster will hold after the next pixEn
//  nextVPix    out  10  line the raster will hold after the next pixEn
//  lineStart   out  1   one-CLK pulse: HPix just became 0
//  frameStart  out  1   one-CLK pulse: (HPix,VPix) just became (0,0)
//  frameCount  out  16  frames started since reset; wraps 0xFFFF->0x0000
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - Divider: clkCount 0..CLK_DIV-1, pixEn registered, high while clkCount==CLK_DIV-1. First pixEn is the CLK_DIV-th cycle after CLR deasserts.
//  - Raster step on pixEn: HPix==H_TOTAL-1 -> HPix=0 and VPix+1; VPix==V_TOTAL-1 at that point -> VPix=0. Otherwise HPix+1.
//  - Reset state: clkCount=0, pixEn=0, HPix=H_TOTAL-1, VPix=V_TOTAL-1, nextHPix=0, nextVPix=0, HSync=1, VSync=1, active=0, vblank=1, lineStart=0, frameStart=0, frameCount=0. The first step therefore lands exactly on (0,0) and fires frameStart.
//  - HSync=0 iff H_ACTIVE+H_FP <= HPix < H_ACTIVE+H_FP+H_SYNC (656..751).
//  - VSync=0 iff V_ACTIVE+V_FP <= VPix < V_ACTIVE+V_FP+V_SYNC (490..491).
//  - HSync, VSync, active and vblank are registered together with HPix/VPix and are always consistent with them in the same cycle. No combinational path from counters to pins.
//  - nextHPix/nextVPix update at the same edge as HPix/VPix and follow the same wrap rules, one step ahead.
//  - lineStart and frameStart are high for exactly the CLK cycle after the step edge; never for CLK_DIV cycles. frameStart implies lineStart.
//  - frameCount increments at the edge that raises frameStart.
//  - CLR mid-frame: at the next edge, all state returns to reset values and the syncs go high. No partial strobe is emitted. CLR overrides a coincident pixEn.
//  - CLR held for several cycles: the outputs hold their reset values and pixEn stays 0.
// STRUCTURE
//  - Shared package vga_pkg: the timing constants above, H_TOTAL/V_TOTAL, sync-window start/end localparams. The sprite mux and text generator reuse these.
//  - Sub-module vga_axis_counter (params TOTAL, ACT, SYNC_S, SYNC_E): count/next/wrap/sync/active for one axis.
//    Instantiate it twice. The H instance is enabled by pixEn; the V instance is enabled by pixEn && H wrap.
//  - The top level holds the divider, strobes and frameCount.
// TESTING
//  - Reset release: CLR 1->0. Require pixEn on cycles 4,8,12,...; after first pixEn edge HPix=0,VPix=0,active=1,frameStart=lineStart=1 for 1 CLK, frameCount=1.
//  - Line timing: across one line count 800 pixEn; HSync low for exactly 96 pixEn with first low at HPix=656; active low from HPix=640.
//  - Frame timing: over one frame count 525 lineStart pulses; VSync low on VPix 490,491 only. Full-frame wrap (799,524)->(0,0) raises frameStart; nextHPix/nextVPix equal (0,0) one step early.
//  - Prefetch: at every pixEn, sampled nextHPix/nextVPix equal HPix/VPix after that edge. Check across the (639,479) and (799,524) boundaries.
//  - Mid-frame CLR at HPix=700,VPix=491 (both syncs low): the next cycle gives HSync=VSync=1, HPix=799, VPix=524, frameCount=0, no strobes.
//  - frameCount wrap: force 65535 frames (or preload in sim). The next frameStart gives frameCount=0x0000.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants (640x480@60 on an 800x525 raster).
// Reused by the timing generator, sprite mux and text generator.
package vga_pkg;

  localparam int unsigned COORD_W  = 10;
  localparam int unsigned FCNT_W   = 16;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned CLK_DIV  = 4;

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are [start, end)
  localparam int unsigned H_SYNC_S = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_E = H_SYNC_S + H_SYNC;
  localparam int unsigned V_SYNC_S = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_E = V_SYNC_S + V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: current position, one-step-ahead position and active-low sync.
// o_next always holds the value o_count takes on the next i_en.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL  = H_TOTAL,
  parameter int unsigned SYNC_S = H_SYNC_S,
  parameter int unsigned SYNC_E = H_SYNC_E
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_adv_next,
  output logic [COORD_W-1:0] o_count,
  output logic [COORD_W-1:0] o_next,
  output logic               o_sync_n,
  output logic               o_wrap_c
);

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] r_next;
  logic               r_sync_n;
  logic [COORD_W-1:0] w_next_inc;

  assign w_next_inc = (r_next == COORD_W'(TOTAL - 1)) ? '0 : r_next + COORD_W'(1);

  // i_adv_next says whether the step after this one moves this axis
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count  <= COORD_W'(TOTAL - 1);
      r_next   <= '0;
      r_sync_n <= 1'b1;
    end else if (i_en) begin
      r_count  <= r_next;
      r_next   <= i_adv_next ? w_next_inc : r_next;
      r_sync_n <= !((r_next >= COORD_W'(SYNC_S)) && (r_next < COORD_W'(SYNC_E)));
    end
  end

  assign o_count  = r_count;
  assign o_next   = r_next;
  assign o_sync_n = r_sync_n;
  assign o_wrap_c = (r_count == COORD_W'(TOTAL - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-enable divider, H/V axis counters, strobes and frame counter.
// All pins come straight from flops; flags are computed from the prefetched coordinates.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP,
  parameter int unsigned CLK_DIV  = vga_pkg::CLK_DIV
) (
  input  logic               CLK,
  input  logic               CLR,
  output logic               pixEn,
  output logic               HSync,
  output logic               VSync,
  output logic [COORD_W-1:0] HPix,
  output logic [COORD_W-1:0] VPix,
  output logic               active,
  output logic               vblank,
  output logic [COORD_W-1:0] nextHPix,
  output logic [COORD_W-1:0] nextVPix,
  output logic               lineStart,
  output logic               frameStart,
  output logic [FCNT_W-1:0]  frameCount
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS  = H_ACTIVE + H_FP;
  localparam int unsigned H_SE  = H_SS + H_SYNC;
  localparam int unsigned V_SS  = V_ACTIVE + V_FP;
  localparam int unsigned V_SE  = V_SS + V_SYNC;
  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0]  r_clk_cnt;
  logic              r_pix_en;
  logic              r_line_start;
  logic              r_frame_start;
  logic              r_active;
  logic              r_vblank;
  logic [FCNT_W-1:0] r_frame_cnt;

  logic              w_h_wrap_c;
  logic              w_v_wrap_c;
  logic              w_v_adv;
  logic              w_line_step;

  // pixEn is registered so it lines up with clkCount == CLK_DIV-1
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_clk_cnt <= '0;
      r_pix_en  <= 1'b0;
    end else begin
      r_clk_cnt <= (r_clk_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : r_clk_cnt + CNT_W'(1);
      r_pix_en  <= (r_clk_cnt == CNT_W'(CLK_DIV - 2));
    end
  end

  // V's lookahead moves once H's lookahead is the last column
  assign w_v_adv     = (nextHPix == COORD_W'(H_TOT - 1));
  assign w_line_step = r_pix_en & w_h_wrap_c;

  vga_axis_counter #(
    .TOTAL (H_TOT),
    .SYNC_S(H_SS),
    .SYNC_E(H_SE)
  ) u_h_axis (
    .i_clk     (CLK),
    .i_rst     (CLR),
    .i_en      (r_pix_en),
    .i_adv_next(1'b1),
    .o_count   (HPix),
    .o_next    (nextHPix),
    .o_sync_n  (HSync),
    .o_wrap_c  (w_h_wrap_c)
  );

  vga_axis_counter #(
    .TOTAL (V_TOT),
    .SYNC_S(V_SS),
    .SYNC_E(V_SE)
  ) u_v_axis (
    .i_clk     (CLK),
    .i_rst     (CLR),
    .i_en      (r_pix_en),
    .i_adv_next(w_v_adv),
    .o_count   (VPix),
    .o_next    (nextVPix),
    .o_sync_n  (VSync),
    .o_wrap_c  (w_v_wrap_c)
  );

  // Strobes last one CLK after the step edge; flags track the coordinates being stepped into
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_active      <= 1'b0;
      r_vblank      <= 1'b1;
      r_frame_cnt   <= '0;
    end else begin
      r_line_start  <= w_line_step;
      r_frame_start <= w_line_step & w_v_wrap_c;
      if (w_line_step && w_v_wrap_c) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
      if (r_pix_en) begin
        r_active <= (nextHPix < COORD_W'(H_ACTIVE)) && (nextVPix < COORD_W'(V_ACTIVE));
        r_vblank <= (nextVPix >= COORD_W'(V_ACTIVE));
      end
    end
  end

  assign pixEn      = r_pix_en;
  assign lineStart  = r_line_start;
  assign frameStart = r_frame_start;
  assign active     = r_active;
  assign vblank     = r_vblank;
  assign frameCount = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-geometry instance (A) and a tiny-geometry instance (B)
// checked every cycle against a position-arithmetic model, plus hand-computed checkpoints.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe, hs, vs, act, vb, ls, fs;
    logic [9:0] hp, vp, nh, nv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr[2];

  logic       a_pe, a_hs, a_vs, a_act, a_vb, a_ls, a_fs;
  logic [9:0] a_hp, a_vp, a_nh, a_nv;
  logic [15:0] a_fc;
  logic       b_pe, b_hs, b_vs, b_act, b_vb, b_ls, b_fs;
  logic [9:0] b_hp, b_vp, b_nh, b_nv;
  logic [15:0] b_fc;

  vga_timing_gen dut_a (
    .CLK(clk), .CLR(clr[0]), .pixEn(a_pe), .HSync(a_hs), .VSync(a_vs),
    .HPix(a_hp), .VPix(a_vp), .active(a_act), .vblank(a_vb),
    .nextHPix(a_nh), .nextVPix(a_nv), .lineStart(a_ls), .frameStart(a_fs),
    .frameCount(a_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(3)
  ) dut_b (
    .CLK(clk), .CLR(clr[1]), .pixEn(b_pe), .HSync(b_hs), .VSync(b_vs),
    .HPix(b_hp), .VPix(b_vp), .active(b_act), .vblank(b_vb),
    .nextHPix(b_nh), .nextVPix(b_nv), .lineStart(b_ls), .frameStart(b_fs),
    .frameCount(b_fc)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mt[2];
  bit          mvalid[2];
  logic [15:0] mfc[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Outputs t cycles after reset: position index = completed steps - 1 on a flat raster
  function automatic exp_t model(input int d, input int t);
    exp_t e;
    int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, dv;
    int ht, vt, tot, n, pos, npos, h, v;
    if (d == 0) begin
      ha = 640; hfp = 16; hsy = 96; hbp = 48; va = 480; vfp = 10; vsy = 2; vbp = 33; dv = 4;
    end else begin
      ha = 8; hfp = 2; hsy = 3; hbp = 2; va = 6; vfp = 1; vsy = 2; vbp = 1; dv = 3;
    end
    ht   = ha + hfp + hsy + hbp;
    vt   = va + vfp + vsy + vbp;
    tot  = ht * vt;
    n    = t / dv;
    pos  = (n + tot - 1) % tot;
    npos = (pos + 1) % tot;
    h    = pos % ht;
    v    = pos / ht;
    e.pe  = (t % dv) == dv - 1;
    e.hs  = !(h >= ha + hfp && h < ha + hfp + hsy);
    e.vs  = !(v >= va + vfp && v < va + vfp + vsy);
    e.act = (h < ha) && (v < va);
    e.vb  = (v >= va);
    e.ls  = (n > 0) && (t % dv == 0) && (h == 0);
    e.fs  = e.ls && (v == 0);
    e.hp  = 10'(h);
    e.vp  = 10'(v);
    e.nh  = 10'(npos % ht);
    e.nv  = 10'(npos / ht);
    return e;
  endfunction

  function automatic exp_t get_dut(input int d);
    if (d == 0) return {a_pe, a_hs, a_vs, a_act, a_vb, a_ls, a_fs, a_hp, a_vp, a_nh, a_nv};
    return {b_pe, b_hs, b_vs, b_act, b_vb, b_ls, b_fs, b_hp, b_vp, b_nh, b_nv};
  endfunction

  // Advance one clock: update the model at the edge, compare both DUTs on the falling edge
  task automatic tick();
    exp_t  e, g;
    string p;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (clr[d]) begin
        mt[d] = 0; mfc[d] = '0; mvalid[d] = 1'b1;
      end else if (mvalid[d]) begin
        mt[d] = mt[d] + 1;
        e = model(d, mt[d]);
        if (e.fs) mfc[d] = mfc[d] + 16'd1;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (mvalid[d]) begin
        e = model(d, mt[d]);
        g = get_dut(d);
        p = (d == 0) ? "A" : "B";
        chk({p, ".pixEn"},      32'(g.pe),  32'(e.pe));
        chk({p, ".HSync"},      32'(g.hs),  32'(e.hs));
        chk({p, ".VSync"},      32'(g.vs),  32'(e.vs));
        chk({p, ".active"},     32'(g.act), 32'(e.act));
        chk({p, ".vblank"},     32'(g.vb),  32'(e.vb));
        chk({p, ".lineStart"},  32'(g.ls),  32'(e.ls));
        chk({p, ".frameStart"}, 32'(g.fs),  32'(e.fs));
        chk({p, ".HPix"},       32'(g.hp),  32'(e.hp));
        chk({p, ".VPix"},       32'(g.vp),  32'(e.vp));
        chk({p, ".nextHPix"},   32'(g.nh),  32'(e.nh));
        chk({p, ".nextVPix"},   32'(g.nv),  32'(e.nv));
        chk({p, ".frameCount"}, 32'((d == 0) ? a_fc : b_fc), 32'(mfc[d]));
      end
    end
  endtask

  initial begin
    int          k, pcnt, hlow, first_hs, first_inact, lcnt;
    bit          seen_e, seen_a;
    logic [15:0] mask;

    mvalid[0] = 1'b0; mvalid[1] = 1'b0;
    mt[0] = 0; mt[1] = 0; mfc[0] = '0; mfc[1] = '0;
    clr[0] = 1'b1; clr[1] = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst.HPix", 32'(a_hp), 799);
    chk("rst.VPix", 32'(a_vp), 524);
    chk("rst.HSync", 32'(a_hs), 1);
    chk("rst.VSync", 32'(a_vs), 1);
    chk("rst.vblank", 32'(a_vb), 1);
    chk("rst.active", 32'(a_act), 0);
    chk("rst.nextHPix", 32'(a_nh), 0);
    chk("rst.frameCount", 32'(a_fc), 0);

    // Reset release: pixEn on the 4th,8th,... cycle with CLR low, first step lands on (0,0)
    clr[0] = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("rel.pixEn", 32'(a_pe), 32'(i % 4 == 3));
      if (i == 4) begin
        chk("rel.HPix", 32'(a_hp), 0);
        chk("rel.VPix", 32'(a_vp), 0);
        chk("rel.active", 32'(a_act), 1);
        chk("rel.frameStart", 32'(a_fs), 1);
        chk("rel.lineStart", 32'(a_ls), 1);
        chk("rel.frameCount", 32'(a_fc), 1);
      end
      if (i == 5) begin
        chk("rel.fs_one_clk", 32'(a_fs), 0);
        chk("rel.ls_one_clk", 32'(a_ls), 0);
      end
    end

    // One full line on A
    k = 0;
    while (!a_ls && k < 4000) begin tick(); k++; end
    chk("line.wait", 32'(k < 4000), 1);
    pcnt = 0; hlow = 0; first_hs = -1; first_inact = -1; k = 0;
    do begin
      if (a_pe) begin
        pcnt++;
        if (!a_hs) begin
          hlow++;
          if (first_hs < 0) first_hs = int'(a_hp);
        end
        if (!a_act && first_inact < 0) first_inact = int'(a_hp);
      end
      tick(); k++;
    end while (!a_ls && k < 4000);
    chk("line.pixEn_count", 32'(pcnt), 800);
    chk("line.hsync_low", 32'(hlow), 96);
    chk("line.hsync_first", 32'(first_hs), 656);
    chk("line.active_end", 32'(first_inact), 640);

    // CLR mid-line on A while HSync is low, on a pixEn cycle
    k = 0;
    while (!(a_hp == 10'd700 && a_pe) && k < 4000) begin tick(); k++; end
    chk("clrA.wait", 32'(k < 4000), 1);
    chk("clrA.pre_hsync", 32'(a_hs), 0);
    clr[0] = 1'b1;
    tick();
    chk("clrA.HSync", 32'(a_hs), 1);
    chk("clrA.HPix", 32'(a_hp), 799);
    chk("clrA.VPix", 32'(a_vp), 524);
    chk("clrA.frameCount", 32'(a_fc), 0);
    chk("clrA.lineStart", 32'(a_ls), 0);
    repeat (3) begin tick(); chk("clrA.hold_pixEn", 32'(a_pe), 0); end
    clr[0] = 1'b0;

    // Full frame on B (15x10 raster, CLK_DIV 3)
    clr[1] = 1'b0;
    k = 0;
    while (!b_fs && k < 1000) begin tick(); k++; end
    chk("frame.wait_first", 32'(k < 1000), 1);
    lcnt = 0; mask = '0; seen_e = 1'b0; seen_a = 1'b0; k = 0;
    do begin
      if (b_pe && b_hp == 10'd14 && b_vp == 10'd9) begin
        seen_e = 1'b1;
        chk("pre.end.nextHPix", 32'(b_nh), 0);
        chk("pre.end.nextVPix", 32'(b_nv), 0);
      end
      if (b_pe && b_hp == 10'd7 && b_vp == 10'd5) begin
        seen_a = 1'b1;
        chk("pre.act.nextHPix", 32'(b_nh), 8);
        chk("pre.act.nextVPix", 32'(b_nv), 5);
      end
      if (b_pe && !b_vs) mask = mask | (16'd1 << b_vp);
      tick(); k++;
      if (b_ls) lcnt++;
    end while (!b_fs && k < 1000);
    chk("frame.wait_next", 32'(k < 1000), 1);
    chk("frame.lineStarts", 32'(lcnt), 10);
    chk("frame.vsync_lines", 32'(mask), 32'h0180);
    chk("frame.seen_end", 32'(seen_e), 1);
    chk("frame.seen_active_edge", 32'(seen_a), 1);
    chk("frame.wrap_HPix", 32'(b_hp), 0);
    chk("frame.wrap_VPix", 32'(b_vp), 0);

    // CLR mid-frame on B with both syncs low, coincident with pixEn
    k = 0;
    while (!(b_hp == 10'd11 && b_vp == 10'd7 && b_pe) && k < 1000) begin tick(); k++; end
    chk("clrB.wait", 32'(k < 1000), 1);
    chk("clrB.pre_syncs", 32'({b_hs, b_vs}), 0);
    clr[1] = 1'b1;
    tick();
    chk("clrB.syncs", 32'({b_hs, b_vs}), 3);
    chk("clrB.HPix", 32'(b_hp), 14);
    chk("clrB.VPix", 32'(b_vp), 9);
    chk("clrB.frameCount", 32'(b_fc), 0);
    chk("clrB.strobes", 32'({b_ls, b_fs}), 0);
    repeat (2) begin tick(); chk("clrB.hold_pixEn", 32'(b_pe), 0); end

    // Random CLR pulses on both instances
    for (int i = 0; i < 20; i++) begin
      clr[1] = 1'b0;
      clr[0] = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(1, 600)) tick();
      clr[1] = 1'b1;
      repeat ($urandom_range(1, 4)) tick();
    end
    clr[0] = 1'b0; clr[1] = 1'b0;

    // frameCount wrap on B via preload
    k = 0;
    while (!b_fs && k < 1000) begin tick(); k++; end
    chk("wrap.wait1", 32'(k < 1000), 1);
    repeat (5) tick();
    force dut_b.r_frame_cnt = 16'hFFFF;
    #1 release dut_b.r_frame_cnt;
    mfc[1] = 16'hFFFF;
    k = 0;
    while (!b_fs && k < 1000) begin tick(); k++; end
    chk("wrap.wait2", 32'(k < 1000), 1);
    chk("wrap.frameCount", 32'(b_fc), 32'h0000);
    tick();
    k = 0;
    while (!b_fs && k < 1000) begin tick(); k++; end
    chk("wrap.wait3", 32'(k < 1000), 1);
    chk("wrap.frameCount_next", 32'(b_fc), 1);

    repeat (20) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
